mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types and constants.
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM status reported back to the memory arbiter
//   arb_state_t - mem_arbiter FSM states
//   req_id_t    - which requester owns the current RAM access
//   TIMEOUT_MAX - access-cycle count at which a stalled RAM access is failed
//   STARVE_MAX  - consecutive data grants tolerated while instruction waits
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} arb_state_t;

  typedef enum logic {REQ_I, REQ_D} req_id_t;

  localparam logic [7:0] TIMEOUT_MAX = 8'd255;
  localparam logic [1:0] STARVE_MAX  = 2'd3;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared RAM port between the instruction and
// data requesters of a CPU. One access at a time: grant in IDLE, drive the
// RAM from latched registers in IACC/DACC until ACCESS, ERROR or timeout,
// then pulse the owner's hit for one RESP cycle.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   iREN, iaddr                   instruction read request and address
//   ihit, iload                   instruction completion pulse, returned word
//   dREN, dWEN, daddr, dstore     data read/write request, address, write data
//   dhit, dload                   data completion pulse, returned word
//   err                           access failed (meaningful with ihit/dhit)
//   ramREN, ramWEN                RAM read/write enables
//   ramaddr, ramstore             RAM address and write data
//   ramload, ramstate             RAM read data and status
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      ihit,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dhit,
  output word_t     dload,
  output logic      err,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  arb_state_t  state;
  word_t       lat_addr;
  word_t       lat_store;
  logic        lat_wr;
  req_id_t     lat_id;
  logic [7:0]  tmo;
  logic [1:0]  starve;

  logic        grant_d;
  logic        grant_i;
  logic        ram_done;
  logic        ram_fail;
  logic        in_access;

  // Data wins in IDLE unless instruction has waited through STARVE_MAX
  // back-to-back data grants.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      if ((dREN || dWEN) && !(iREN && (starve == STARVE_MAX)))
        grant_d = 1'b1;
      else if (iREN)
        grant_i = 1'b1;
    end
  end

  // Timeout fires on the cycle the count would reach TIMEOUT_MAX, giving
  // exactly TIMEOUT_MAX access cycles before giving up.
  always_comb begin
    in_access = (state == IACC) || (state == DACC);
    ram_done  = (ramstate == ACCESS);
    ram_fail  = (ramstate == ERROR) || ((tmo + 8'd1) == TIMEOUT_MAX);
    ramREN    = in_access && !lat_wr;
    ramWEN    = in_access && lat_wr;
  end

  assign ramaddr  = lat_addr;
  assign ramstore = lat_store;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_store <= '0;
      lat_wr    <= 1'b0;
      lat_id    <= REQ_I;
      tmo       <= '0;
      starve    <= '0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      err       <= 1'b0;
      iload     <= '0;
      dload     <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= DACC;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wr    <= dWEN;
            lat_id    <= REQ_D;
            tmo       <= '0;
            starve    <= iREN ? starve + 2'd1 : '0;
          end else if (grant_i) begin
            state     <= IACC;
            lat_addr  <= iaddr;
            lat_store <= '0;
            lat_wr    <= 1'b0;
            lat_id    <= REQ_I;
            tmo       <= '0;
            starve    <= '0;
          end
        end
        IACC, DACC: begin
          if (ram_done || ram_fail) begin
            state <= RESP;
            err   <= !ram_done;
            if (lat_id == REQ_D) begin
              dhit  <= 1'b1;
              dload <= ram_done ? ramload : '0;
            end else begin
              ihit  <= 1'b1;
              iload <= ram_done ? ramload : '0;
            end
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN;
  word_t     iaddr;
  logic      ihit;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dhit;
  word_t     dload;
  logic      err;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .err(err),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: 0 = nobody holds the RAM, 1 = instruction, 2 = data
  int    m_owner = 0;
  bit    m_wr;
  word_t m_addr;
  word_t m_store;
  int    m_age;
  bit    m_resp;
  int    m_resp_owner;
  bit    m_err;
  word_t m_iload;
  word_t m_dload;
  int    m_streak;
  bit    m_valid = 1'b0;
  bit    want_d;
  bit    force_i;

  task automatic m_complete(input word_t data, input bit e);
    m_resp       = 1'b1;
    m_resp_owner = m_owner;
    m_err        = e;
    if (m_owner == 1) m_iload = data;
    else              m_dload = data;
    m_owner      = 0;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      m_owner = 0; m_wr = 0; m_addr = 0; m_store = 0; m_age = 0;
      m_resp = 0; m_resp_owner = 0; m_err = 0; m_iload = 0; m_dload = 0;
      m_streak = 0; m_valid = 1'b1;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_owner != 0) begin
      if (ramstate == ACCESS)                        m_complete(ramload, 1'b0);
      else if (ramstate == ERROR || m_age + 1 >= 255) m_complete('0, 1'b1);
      else                                           m_age++;
    end else begin
      want_d  = dREN || dWEN;
      force_i = iREN && (m_streak >= 3);
      if (want_d && !force_i) begin
        m_owner = 2; m_wr = dWEN; m_addr = daddr; m_store = dstore; m_age = 0;
        m_streak = iREN ? m_streak + 1 : 0;
      end else if (iREN) begin
        m_owner = 1; m_wr = 0; m_addr = iaddr; m_store = 0; m_age = 0;
        m_streak = 0;
      end
    end
  end

  // Single compare process: every cycle once the model has seen a reset.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("ramREN", ramREN, (m_owner == 1) || (m_owner == 2 && !m_wr));
      check("ramWEN", ramWEN, (m_owner == 2) && m_wr);
      if (m_owner != 0) check("ramaddr", ramaddr, m_addr);
      if (m_owner == 2 && m_wr) check("ramstore", ramstore, m_store);
      check("ihit", ihit, m_resp && m_resp_owner == 1);
      check("dhit", dhit, m_resp && m_resp_owner == 2);
      if (m_resp) check("err", err, m_err);
      check("iload", iload, m_iload);
      check("dload", dload, m_dload);
    end
  end

  // ---------------- directed RAM responder ----------------
  int    r_en, r_first, r_hit_t;
  bit    r_i, r_d, r_err, r_wr, r_done;
  word_t r_load, r_addr, r_store;

  // Answers BUSY for the first busy_n enable cycles, then fin; returns at hit.
  task automatic serve(input int busy_n, input ramstate_t fin, input word_t data);
    r_en = 0; r_first = -1; r_hit_t = -1; r_i = 0; r_d = 0; r_err = 0;
    r_wr = 0; r_load = 0; r_addr = 0; r_store = 0; r_done = 0;
    ramstate = FREE;
    for (int t = 0; t < 600 && !r_done; t++) begin
      @(negedge CLK);
      if (ihit || dhit) begin
        r_i = ihit; r_d = dhit; r_load = ihit ? iload : dload; r_err = err;
        r_hit_t = t; r_done = 1; ramstate = FREE;
      end else if (ramREN || ramWEN) begin
        if (r_en == 0) r_first = t;
        r_en++;
        r_wr = ramWEN; r_addr = ramaddr; r_store = ramstore;
        ramstate = (r_en > busy_n) ? fin : BUSY;
        ramload  = data;
      end else begin
        ramstate = FREE;
      end
    end
    if (!r_done) begin
      n_checks++; n_fail++;
      $display("FAIL serve_timeout: no hit within 600 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    RST = 0;
    @(negedge CLK);
    check("rst_ihit", ihit, 0);
    check("rst_dhit", dhit, 0);
    check("rst_ramREN", ramREN, 0);
    check("rst_iload", iload, 0);

    // Instruction read, two BUSY cycles then ACCESS.
    iREN = 1; iaddr = 32'h40;
    serve(2, ACCESS, 32'hDEADBEEF);
    iREN = 0;
    check("A_en_cycles", r_en, 3);
    check("A_first_en", r_first, 0);
    check("A_wr", r_wr, 0);
    check("A_addr", r_addr, 32'h40);
    check("A_hit_lat", r_hit_t, r_first + 3);
    check("A_ihit", r_i, 1);
    check("A_dhit", r_d, 0);
    check("A_load", r_load, 32'hDEADBEEF);
    check("A_err", r_err, 0);
    check("A_model_iload", m_iload, 32'hDEADBEEF);

    // Simultaneous I and D write: data goes first, instruction after RESP.
    iREN = 1; iaddr = 32'h100; dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h1234;
    serve(0, ACCESS, 32'h0000AAAA);
    dREN = 0; dWEN = 0;
    check("B_wr", r_wr, 1);
    check("B_addr", r_addr, 32'h80);
    check("B_store", r_store, 32'h1234);
    check("B_dhit", r_d, 1);
    serve(0, ACCESS, 32'h00005555);
    iREN = 0;
    check("B_ihit", r_i, 1);
    check("B_iaddr", r_addr, 32'h100);
    check("B_regrant", r_first, 1);
    check("B_iload", r_load, 32'h5555);

    // Held dREN with iREN: three data grants then one instruction grant.
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    for (int k = 0; k < 8; k++) begin
      serve(0, ACCESS, $urandom);
      check("C_pattern_d", r_d, (k % 4) != 3);
    end
    iREN = 0; dREN = 0;

    // RAM stuck BUSY: times out after 255 access cycles.
    dREN = 1; daddr = 32'h400;
    serve(100000, BUSY, 32'h11111111);
    dREN = 0;
    check("D_en_cycles", r_en, 255);
    check("D_dhit", r_d, 1);
    check("D_err", r_err, 1);
    check("D_load", r_load, 0);

    // ERROR on the second access cycle.
    iREN = 1; iaddr = 32'h500;
    serve(1, ERROR, 32'h77);
    iREN = 0;
    check("E_en_cycles", r_en, 2);
    check("E_ihit", r_i, 1);
    check("E_err", r_err, 1);
    check("E_load", r_load, 0);
    check("E_model_err", m_err, 1);

    // Reset in the middle of a data access.
    dREN = 1; daddr = 32'h600;
    r = 0;
    for (int t = 0; t < 10 && r == 0; t++) begin
      @(negedge CLK);
      if (ramREN) r = 1;
    end
    check("F_reached_dacc", r, 1);
    ramstate = BUSY;
    RST = 1;
    @(negedge CLK);
    RST = 0; dREN = 0; ramstate = FREE;
    check("F_ramREN", ramREN, 0);
    check("F_ramWEN", ramWEN, 0);
    check("F_dhit", dhit, 0);
    check("F_dload", dload, 0);
    repeat (3) begin
      @(negedge CLK);
      check("F_no_dhit", dhit, 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST    = ($urandom_range(0, 199) == 0);
      iREN   = ($urandom_range(0, 2) != 0);
      dREN   = ($urandom_range(0, 2) == 0);
      dWEN   = ($urandom_range(0, 3) == 0);
      iaddr  = $urandom;
      daddr  = $urandom;
      dstore = $urandom;
      ramload = $urandom;
      r = $urandom_range(0, 9);
      ramstate = (r < 5) ? BUSY : (r < 8) ? ACCESS : (r < 9) ? ERROR : FREE;
    end
    RST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = ACCESS;
    repeat (5) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
